// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: LANES bytes per cycle through a composite-field
// GF(((2^2)^2)^2) inverter, with a valid/ready handshake on both sides.
module aes_inv_sub_bytes_seq #(
    parameter int unsigned LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
            $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam int unsigned NUM_STEPS = 16 / LANES;
    localparam logic [3:0]  LAST_CNT  = 4'(NUM_STEPS - 1);

    // GF(2^2): basis {w, 1}, w^2 = w + 1; GF(2^4) over it uses y^2 + y + w.
    localparam logic [1:0] GF4_N = 2'b10;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic hh;
        hh = a[1] & b[1];
        return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
    endfunction

    // Squaring doubles as inversion in GF(2^2).
    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul(hh, GF4_N) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] d;
        logic [1:0] di;
        d  = gf4_mul(gf4_sq(a[3:2]), GF4_N) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
        di = gf4_sq(d);
        return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
    endfunction

    // Smallest lambda making z^2 + z + lambda irreducible over GF(2^4).
    function automatic logic [3:0] find_lambda();
        logic [3:0] lam;
        logic       found;
        logic       ok;
        lam   = 4'h1;
        found = 1'b0;
        for (int unsigned v = 1; v < 16; v++) begin
            ok = 1'b1;
            for (int unsigned t = 0; t < 16; t++) begin
                if ((gf16_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(v)) ok = 1'b0;
            end
            if (ok && !found) begin
                lam   = 4'(v);
                found = 1'b1;
            end
        end
        return lam;
    endfunction

    localparam logic [3:0] GF16_L = find_lambda();

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, GF16_L) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    function automatic logic [7:0] gf256_inv(input logic [7:0] a);
        logic [3:0] d;
        logic [3:0] di;
        d  = gf16_mul(gf16_mul(a[7:4], a[7:4]), GF16_L) ^ gf16_mul(a[7:4], a[3:0])
           ^ gf16_mul(a[3:0], a[3:0]);
        di = gf16_inv(d);
        return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
    endfunction

    // Polynomial-to-tower map: x^i goes to beta^i, beta a tower root of x^8+x^4+x^3+x+1.
    function automatic logic [63:0] calc_fwd_cols();
        logic [63:0] cols;
        logic [7:0]  beta;
        logic [7:0]  b;
        logic [7:0]  b2;
        logic [7:0]  b4;
        logic [7:0]  p;
        logic        found;
        beta  = 8'h02;
        found = 1'b0;
        for (int unsigned c = 1; c < 256; c++) begin
            b  = 8'(c);
            b2 = gf256_mul(b, b);
            b4 = gf256_mul(b2, b2);
            if (!found && ((gf256_mul(b4, b4) ^ b4 ^ gf256_mul(b2, b) ^ b ^ 8'h01) == 8'h00)) begin
                beta  = b;
                found = 1'b1;
            end
        end
        cols = '0;
        p    = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            cols[{3'(i), 3'b000} +: 8] = p;
            p = gf256_mul(p, beta);
        end
        return cols;
    endfunction

    function automatic logic [7:0] apply_map(input logic [7:0] x, input logic [63:0] cols);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (x[3'(i)]) r = r ^ cols[{3'(i), 3'b000} +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] calc_inv_cols(input logic [63:0] fwd);
        logic [63:0] cols;
        cols = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            for (int unsigned a = 0; a < 256; a++) begin
                if (apply_map(8'(a), fwd) == (8'h01 << 3'(j))) cols[{3'(j), 3'b000} +: 8] = 8'(a);
            end
        end
        return cols;
    endfunction

    localparam logic [63:0] FWD_COLS = calc_fwd_cols();
    localparam logic [63:0] INV_COLS = calc_inv_cols(FWD_COLS);

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return apply_map(gf256_inv(apply_map(inv_affine(s), FWD_COLS)), INV_COLS);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;

    logic [LANES*8-1:0] groups [16];
    logic [LANES*8-1:0] group_sel;
    logic [LANES*8-1:0] group_sub;
    logic [127:0]       run_state;

    // Lane group cnt is muxed out, substituted, and written back in place.
    generate
        for (genvar g = 0; g < 16; g++) begin : g_groups
            if (g < NUM_STEPS) begin : g_used
                assign groups[g] = work_q[g*LANES*8 +: LANES*8];
                assign run_state[g*LANES*8 +: LANES*8] =
                    (cnt_q == 4'(g)) ? group_sub : work_q[g*LANES*8 +: LANES*8];
            end else begin : g_unused
                assign groups[g] = '0;
            end
        end
        for (genvar l = 0; l < LANES; l++) begin : g_lanes
            assign group_sub[l*8 +: 8] = inv_sbox(group_sel[l*8 +: 8]);
        end
    endgenerate

    assign group_sel = groups[cnt_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = run_state;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Directed self-checking bench for aes_inv_sub_bytes_seq; one instance per legal LANES value.
module tb_aes_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         in_ready_a  [5];
    logic         out_valid_a [5];
    logic [127:0] out_state_a [5];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        aes_inv_sub_bytes_seq #(.LANES(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[gi]),
            .in_state  (in_state),
            .out_valid (out_valid_a[gi]),
            .out_ready (out_ready),
            .out_state (out_state_a[gi])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] KV_IN   = 128'h0000_0000_0000_0000_0000_ED16_0100_7C63;
    localparam logic [127:0] KV_OUT  = 128'h5252_5252_5252_5252_5252_53FF_0952_0100;
    localparam logic [127:0] KV_PART = 128'h0000_0000_0000_0000_0052_53FF_0952_0100;
    localparam logic [127:0] B_IN    = {16{8'h16}};
    localparam logic [127:0] B_OUT   = {16{8'hFF}};
    localparam logic [127:0] C_IN    = {16{8'h7C}};
    localparam logic [127:0] C_OUT   = {16{8'h01}};

    logic [7:0]   fsbox [256];
    logic [127:0] bb_in  [3];
    logic [127:0] bb_exp [3];
    int           lat_a  [5];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    task automatic build_fsbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fsbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] st);
        check("accept_ready", 128'(in_ready_a[0]), 128'(1));
        in_state = st;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done0(output int lat);
        lat = 0;
        while (!out_valid_a[0] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake0();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_in_ready", 128'(in_ready_a[0]), 128'(1));
        check("post_hs_out_valid", 128'(out_valid_a[0]), 128'(0));
    endtask

    initial begin
        int           lat;
        int           n;
        int           nin;
        int           nout;
        int           last_t;
        logic         seen;
        logic         acc;
        logic         done_all;
        logic [127:0] st;
        logic [127:0] rec;

        build_fsbox();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_state  = KV_IN;
        out_ready = 1'b0;

        // Reset held two cycles with in_valid asserted.
        tick();
        check("rst1_out_valid", 128'(out_valid_a[0]), 128'(0));
        check("rst1_out_state", out_state_a[0], '0);
        tick();
        check("rst2_out_valid", 128'(out_valid_a[0]), 128'(0));
        check("rst2_out_state", out_state_a[0], '0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_in_ready", 128'(in_ready_a[0]), 128'(1));
        check("post_rst_out_valid", 128'(out_valid_a[0]), 128'(0));

        // Known bytes on LANES=1.
        accept(KV_IN);
        wait_done0(lat);
        check("kv_latency", 128'(lat), 128'(16));
        check("kv_out", out_state_a[0], KV_OUT);
        handshake0();

        // Backpressure with in_valid/in_state churning.
        accept(B_IN);
        wait_done0(lat);
        check("bp_latency", 128'(lat), 128'(16));
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = {4{$urandom}};
            tick();
            check("bp_out_state", out_state_a[0], B_OUT);
            check("bp_out_valid", 128'(out_valid_a[0]), 128'(1));
            check("bp_in_ready", 128'(in_ready_a[0]), 128'(0));
        end
        in_valid = 1'b0;
        handshake0();

        // Abort at cnt=7: seven bytes done, byte 7 still raw.
        accept(KV_IN);
        repeat (7) tick();
        check("abort_partial", out_state_a[0], KV_PART);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_state", out_state_a[0], '0);
        check("abort_in_ready", 128'(in_ready_a[0]), 128'(1));
        seen = 1'b0;
        check("abort_out_valid", 128'(out_valid_a[0]), 128'(0));
        repeat (30) begin
            tick();
            if (out_valid_a[0]) seen = 1'b1;
        end
        check("abort_no_pulse", 128'(seen), 128'(0));
        accept(KV_IN);
        wait_done0(lat);
        check("after_abort_latency", 128'(lat), 128'(16));
        check("after_abort_out", out_state_a[0], KV_OUT);
        handshake0();

        // Exhaustive round trip on every LANES instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < 16; b++) st[b*8 +: 8] = 8'(s * 16 + b);
            for (int i = 0; i < 5; i++) lat_a[i] = 0;
            in_state = st;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n        = 0;
            done_all = 1'b0;
            while (!done_all && n < 40) begin
                tick();
                n++;
                done_all = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    if (out_valid_a[i] && lat_a[i] == 0) lat_a[i] = n;
                    if (!out_valid_a[i]) done_all = 1'b0;
                end
            end
            for (int i = 0; i < 5; i++) begin
                check("rt_latency", 128'(lat_a[i]), 128'(16 >> i));
                for (int b = 0; b < 16; b++) rec[b*8 +: 8] = fsbox[out_state_a[i][b*8 +: 8]];
                check("rt_recovered", rec, st);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Back-to-back on LANES=1 with out_ready held high.
        bb_in[0]  = KV_IN;  bb_exp[0] = KV_OUT;
        bb_in[1]  = B_IN;   bb_exp[1] = B_OUT;
        bb_in[2]  = C_IN;   bb_exp[2] = C_OUT;
        in_state  = bb_in[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nin       = 0;
        nout      = 0;
        last_t    = 0;
        for (int k = 0; k < 100 && nout < 3; k++) begin
            acc = in_valid && in_ready_a[0];
            tick();
            if (acc) begin
                nin++;
                if (nin < 3) in_state = bb_in[nin];
                else in_valid = 1'b0;
            end
            if (out_valid_a[0]) begin
                check("b2b_out", out_state_a[0], bb_exp[nout]);
                if (nout > 0) check("b2b_spacing", 128'(cyc - last_t), 128'(18));
                last_t = cyc;
                nout++;
            end
        end
        check("b2b_count", 128'(nout), 128'(3));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
